// File: rtl/input_to_output_credit_pipe.sv
// Switch-traversal stage: qualifies per-outport SA grants against downstream
// per-VC credit counters, pops the input buffers and launches the crossbar select.
module input_to_output_credit_pipe #(
    parameter int INPUT_PORT_NUM  = 6,
    parameter int OUTPUT_PORT_NUM = 6,
    parameter int VC_NUM          = 4,
    parameter int VC_ID_W         = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
    parameter int INPORT_ID_W     = (INPUT_PORT_NUM > 1) ? $clog2(INPUT_PORT_NUM) : 1,
    parameter int VC_DEPTH        = 4,
    parameter int CRD_W           = $clog2(VC_DEPTH + 1),
    parameter int LA_ROUTE_W      = 3
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic [OUTPUT_PORT_NUM-1:0]             sa_global_vld_i,
    input  logic [OUTPUT_PORT_NUM*INPUT_PORT_NUM-1:0] sa_global_inport_id_oh_i,
    input  logic [OUTPUT_PORT_NUM*VC_ID_W-1:0]     sa_global_inport_vc_id_i,
    input  logic [OUTPUT_PORT_NUM-1:0]             vc_assignment_vld_i,
    input  logic [OUTPUT_PORT_NUM*VC_ID_W-1:0]     vc_assignment_vc_id_i,
    input  logic [OUTPUT_PORT_NUM*LA_ROUTE_W-1:0]  look_ahead_routing_sel_i,
    input  logic [OUTPUT_PORT_NUM-1:0]             credit_return_vld_i,
    input  logic [OUTPUT_PORT_NUM*VC_ID_W-1:0]     credit_return_vc_id_i,
    output logic [INPUT_PORT_NUM-1:0]              inport_read_enable_o,
    output logic [INPUT_PORT_NUM*VC_ID_W-1:0]      inport_read_vc_id_o,
    output logic [OUTPUT_PORT_NUM-1:0]             outport_vld_o,
    output logic [OUTPUT_PORT_NUM*INPORT_ID_W-1:0] outport_select_inport_id_o,
    output logic [OUTPUT_PORT_NUM*VC_ID_W-1:0]     outport_vc_id_o,
    output logic [OUTPUT_PORT_NUM*LA_ROUTE_W-1:0]  outport_look_ahead_routing_o,
    output logic [OUTPUT_PORT_NUM*VC_NUM-1:0]      vc_credit_avail_o,
    output logic                                   credit_overflow_err_o,
    output logic                                   inport_conflict_err_o
);

    localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(VC_DEPTH);

    logic [OUTPUT_PORT_NUM-1:0]             fire;
    logic [OUTPUT_PORT_NUM*INPORT_ID_W-1:0] sel_flat;
    logic [OUTPUT_PORT_NUM*VC_NUM-1:0]      ovf_hit;
    logic                                   conflict_hit;
    logic [OUTPUT_PORT_NUM-1:0]             vld_reg;
    logic                                   ovf_err_reg;
    logic                                   conflict_err_reg;

    genvar gi, gv;
    generate
        for (gi = 0; gi < OUTPUT_PORT_NUM; gi++) begin : g_out
            logic [INPUT_PORT_NUM-1:0] oh;
            logic [VC_ID_W-1:0]        va_vc;
            logic [VC_ID_W-1:0]        ret_vc;
            logic [INPORT_ID_W-1:0]    sel_idx;
            logic [VC_NUM-1:0]         nz;
            logic [INPORT_ID_W-1:0]    sel_reg;
            logic [VC_ID_W-1:0]        vc_reg;
            logic [LA_ROUTE_W-1:0]     la_reg;

            assign oh     = sa_global_inport_id_oh_i[gi*INPUT_PORT_NUM +: INPUT_PORT_NUM];
            assign va_vc  = vc_assignment_vc_id_i[gi*VC_ID_W +: VC_ID_W];
            assign ret_vc = credit_return_vc_id_i[gi*VC_ID_W +: VC_ID_W];

            // Scan from the top so the lowest set bit wins on a malformed one-hot.
            always_comb begin
                sel_idx = '0;
                for (int i = INPUT_PORT_NUM - 1; i >= 0; i--) begin
                    if (oh[i]) sel_idx = INPORT_ID_W'(i);
                end
            end

            assign sel_flat[gi*INPORT_ID_W +: INPORT_ID_W] = sel_idx;
            assign fire[gi] = sa_global_vld_i[gi] & vc_assignment_vld_i[gi] & (|oh) & nz[va_vc];

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    sel_reg <= '0;
                    vc_reg  <= '0;
                    la_reg  <= '0;
                end else if (fire[gi]) begin
                    sel_reg <= sel_idx;
                    vc_reg  <= va_vc;
                    la_reg  <= look_ahead_routing_sel_i[gi*LA_ROUTE_W +: LA_ROUTE_W];
                end
            end

            assign outport_select_inport_id_o[gi*INPORT_ID_W +: INPORT_ID_W] = sel_reg;
            assign outport_vc_id_o[gi*VC_ID_W +: VC_ID_W]                    = vc_reg;
            assign outport_look_ahead_routing_o[gi*LA_ROUTE_W +: LA_ROUTE_W] = la_reg;

            for (gv = 0; gv < VC_NUM; gv++) begin : g_vc
                logic             dec;
                logic             inc;
                logic [CRD_W-1:0] crd_reg;

                assign dec = fire[gi] & (va_vc == VC_ID_W'(gv));
                assign inc = credit_return_vld_i[gi] & (ret_vc == VC_ID_W'(gv));

                // A simultaneous grant and return cancel out; fire already excludes an empty counter.
                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        crd_reg <= CRD_FULL;
                    end else if (dec && !inc) begin
                        crd_reg <= crd_reg - CRD_W'(1);
                    end else if (inc && !dec && crd_reg != CRD_FULL) begin
                        crd_reg <= crd_reg + CRD_W'(1);
                    end
                end

                assign nz[gv] = (crd_reg != '0);
                assign ovf_hit[gi*VC_NUM + gv] = inc & ~dec & (crd_reg == CRD_FULL);
                assign vc_credit_avail_o[gi*VC_NUM + gv] = nz[gv];
            end
        end
    endgenerate

    // Lowest-index firing outport owns the read VC id of a shared inport.
    always_comb begin
        inport_read_enable_o = '0;
        inport_read_vc_id_o  = '0;
        conflict_hit         = 1'b0;
        for (int i = 0; i < INPUT_PORT_NUM; i++) begin
            for (int o = OUTPUT_PORT_NUM - 1; o >= 0; o--) begin
                if (fire[o] && sel_flat[o*INPORT_ID_W +: INPORT_ID_W] == INPORT_ID_W'(i)) begin
                    inport_read_enable_o[i]                  = 1'b1;
                    inport_read_vc_id_o[i*VC_ID_W +: VC_ID_W] = sa_global_inport_vc_id_i[o*VC_ID_W +: VC_ID_W];
                end
            end
        end
        for (int o = 0; o < OUTPUT_PORT_NUM; o++) begin
            for (int p = o + 1; p < OUTPUT_PORT_NUM; p++) begin
                if (fire[o] && fire[p] &&
                    sel_flat[o*INPORT_ID_W +: INPORT_ID_W] == sel_flat[p*INPORT_ID_W +: INPORT_ID_W]) begin
                    conflict_hit = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_reg          <= '0;
            ovf_err_reg      <= 1'b0;
            conflict_err_reg <= 1'b0;
        end else begin
            vld_reg          <= fire;
            ovf_err_reg      <= ovf_err_reg | (|ovf_hit);
            conflict_err_reg <= conflict_err_reg | conflict_hit;
        end
    end

    assign outport_vld_o         = vld_reg;
    assign credit_overflow_err_o = ovf_err_reg;
    assign inport_conflict_err_o = conflict_err_reg;

endmodule

// File: tb/tb_input_to_output_credit_pipe.sv
// Bench for input_to_output_credit_pipe: directed vector table, reset corner
// sequence and randomized traffic against a credit-accounting reference model.
module tb_input_to_output_credit_pipe;

    localparam int O  = 6;
    localparam int I  = 6;
    localparam int V  = 4;
    localparam int VW = 2;
    localparam int IW = 3;
    localparam int LW = 3;
    localparam int D  = 4;

    typedef struct {
        logic [O-1:0]    sa_vld;
        logic [O*I-1:0]  oh;
        logic [O*VW-1:0] invc;
        logic [O-1:0]    va_vld;
        logic [O*VW-1:0] vavc;
        logic [O*LW-1:0] la;
        logic [O-1:0]    cr_vld;
        logic [O*VW-1:0] crvc;
        logic [I-1:0]    exp_ren;
        logic [O-1:0]    exp_vld;
    } vec_t;

    logic clk;
    logic rstn;
    vec_t cur;

    logic [I-1:0]    inport_read_enable_o;
    logic [I*VW-1:0] inport_read_vc_id_o;
    logic [O-1:0]    outport_vld_o;
    logic [O*IW-1:0] outport_select_inport_id_o;
    logic [O*VW-1:0] outport_vc_id_o;
    logic [O*LW-1:0] outport_look_ahead_routing_o;
    logic [O*V-1:0]  vc_credit_avail_o;
    logic            credit_overflow_err_o;
    logic            inport_conflict_err_o;

    input_to_output_credit_pipe dut (
        .clk                          (clk),
        .rstn                         (rstn),
        .sa_global_vld_i              (cur.sa_vld),
        .sa_global_inport_id_oh_i     (cur.oh),
        .sa_global_inport_vc_id_i     (cur.invc),
        .vc_assignment_vld_i          (cur.va_vld),
        .vc_assignment_vc_id_i        (cur.vavc),
        .look_ahead_routing_sel_i     (cur.la),
        .credit_return_vld_i          (cur.cr_vld),
        .credit_return_vc_id_i        (cur.crvc),
        .inport_read_enable_o         (inport_read_enable_o),
        .inport_read_vc_id_o          (inport_read_vc_id_o),
        .outport_vld_o                (outport_vld_o),
        .outport_select_inport_id_o   (outport_select_inport_id_o),
        .outport_vc_id_o              (outport_vc_id_o),
        .outport_look_ahead_routing_o (outport_look_ahead_routing_o),
        .vc_credit_avail_o            (vc_credit_avail_o),
        .credit_overflow_err_o        (credit_overflow_err_o),
        .inport_conflict_err_o        (inport_conflict_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int n_step = 0;

    // Reference state: credits as plain integers, expected launch registers.
    int           m_crd [O][V];
    int           m_selv[O];
    logic [O-1:0] m_fire;
    logic [O-1:0] m_vld;
    logic [O*IW-1:0] m_sel_vec;
    logic [O*VW-1:0] m_vc_vec;
    logic [O*LW-1:0] m_la_vec;
    bit           m_ovf;
    bit           m_conf;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (step %0d)", nm, act, exp, n_step);
        else pass_cnt++;
    endtask

    task automatic model_reset();
        for (int o = 0; o < O; o++) for (int v = 0; v < V; v++) m_crd[o][v] = D;
        m_vld = '0; m_sel_vec = '0; m_vc_vec = '0; m_la_vec = '0;
        m_ovf = 0; m_conf = 0;
    endtask

    function automatic vec_t grant(vec_t v, int o, int oh, int invc, int vavc, int la);
        vec_t r = v;
        r.sa_vld[o] = 1'b1;
        r.va_vld[o] = 1'b1;
        r.oh[o*I +: I]    = I'(oh);
        r.invc[o*VW +: VW] = VW'(invc);
        r.vavc[o*VW +: VW] = VW'(vavc);
        r.la[o*LW +: LW]   = LW'(la);
        return r;
    endfunction

    function automatic vec_t ret(vec_t v, int o, int vc);
        vec_t r = v;
        r.cr_vld[o] = 1'b1;
        r.crvc[o*VW +: VW] = VW'(vc);
        return r;
    endfunction

    function automatic vec_t with_exp(vec_t v, int ren, int vld);
        vec_t r = v;
        r.exp_ren = I'(ren);
        r.exp_vld = O'(vld);
        return r;
    endfunction

    // Starts just after a rising edge, ends just after the next one.
    task automatic step(input vec_t v, input bit has_exp);
        logic [I-1:0]    oh;
        logic [I-1:0]    e_ren;
        logic [I*VW-1:0] e_rvc;
        logic [O*V-1:0]  e_av;
        int vavc, nf, dec, inc;
        cur = v;
        #4;
        for (int o = 0; o < O; o++) begin
            oh = v.oh[o*I +: I];
            m_selv[o] = -1;
            for (int i = 0; i < I; i++) if (oh[i] && m_selv[o] < 0) m_selv[o] = i;
            vavc = int'(v.vavc[o*VW +: VW]);
            m_fire[o] = v.sa_vld[o] && v.va_vld[o] && (m_selv[o] >= 0) && (m_crd[o][vavc] > 0);
        end
        e_ren = '0; e_rvc = '0;
        for (int i = 0; i < I; i++)
            for (int o = 0; o < O; o++)
                if (m_fire[o] && m_selv[o] == i && !e_ren[i]) begin
                    e_ren[i] = 1'b1;
                    e_rvc[i*VW +: VW] = v.invc[o*VW +: VW];
                end
        for (int o = 0; o < O; o++) for (int vv = 0; vv < V; vv++) e_av[o*V + vv] = (m_crd[o][vv] > 0);
        chk("read_en", 64'(inport_read_enable_o), 64'(e_ren));
        chk("read_vc", 64'(inport_read_vc_id_o), 64'(e_rvc));
        chk("credit_avail", 64'(vc_credit_avail_o), 64'(e_av));
        if (has_exp) chk("tbl_read_en", 64'(inport_read_enable_o), 64'(v.exp_ren));
        @(posedge clk);
        #1;
        for (int i = 0; i < I; i++) begin
            nf = 0;
            for (int o = 0; o < O; o++) if (m_fire[o] && m_selv[o] == i) nf++;
            if (nf > 1) m_conf = 1;
        end
        for (int o = 0; o < O; o++) begin
            m_vld[o] = m_fire[o];
            if (m_fire[o]) begin
                m_sel_vec[o*IW +: IW] = IW'(m_selv[o]);
                m_vc_vec[o*VW +: VW]  = v.vavc[o*VW +: VW];
                m_la_vec[o*LW +: LW]  = v.la[o*LW +: LW];
            end
            for (int vv = 0; vv < V; vv++) begin
                dec = (m_fire[o] && int'(v.vavc[o*VW +: VW]) == vv) ? 1 : 0;
                inc = (v.cr_vld[o] && int'(v.crvc[o*VW +: VW]) == vv) ? 1 : 0;
                if (dec == 1 && inc == 0) m_crd[o][vv]--;
                else if (inc == 1 && dec == 0) begin
                    if (m_crd[o][vv] == D) m_ovf = 1;
                    else m_crd[o][vv]++;
                end
            end
        end
        chk("outport_vld", 64'(outport_vld_o), 64'(m_vld));
        chk("outport_sel", 64'(outport_select_inport_id_o), 64'(m_sel_vec));
        chk("outport_vc", 64'(outport_vc_id_o), 64'(m_vc_vec));
        chk("outport_la", 64'(outport_look_ahead_routing_o), 64'(m_la_vec));
        chk("overflow_err", 64'(credit_overflow_err_o), 64'(m_ovf));
        chk("conflict_err", 64'(inport_conflict_err_o), 64'(m_conf));
        if (has_exp) chk("tbl_outport_vld", 64'(outport_vld_o), 64'(v.exp_vld));
        $display("step %0d ren=%b vld=%b avail=%h ovf=%0b conf=%0b", n_step,
                 inport_read_enable_o, outport_vld_o, vc_credit_avail_o,
                 credit_overflow_err_o, inport_conflict_err_o);
        n_step++;
    endtask

    function automatic vec_t rand_vec();
        vec_t r = '{default: '0};
        int k;
        for (int o = 0; o < O; o++) begin
            r.sa_vld[o] = ($urandom_range(0, 99) < 60);
            r.va_vld[o] = ($urandom_range(0, 99) < 85);
            k = $urandom_range(0, 9);
            if (k == 0) r.oh[o*I +: I] = '0;
            else if (k <= 7) r.oh[o*I +: I] = I'(1 << $urandom_range(0, I - 1));
            else r.oh[o*I +: I] = I'($urandom);
            r.invc[o*VW +: VW] = VW'($urandom);
            r.vavc[o*VW +: VW] = VW'($urandom);
            r.la[o*LW +: LW]   = LW'($urandom);
            r.cr_vld[o] = ($urandom_range(0, 99) < 30);
            r.crvc[o*VW +: VW] = VW'($urandom);
        end
        return r;
    endfunction

    vec_t z;
    vec_t t;
    vec_t tbl[$];

    initial begin
        z = '{default: '0};
        cur = z;
        rstn = 1'b0;
        model_reset();

        // Directed vectors.
        tbl.push_back(with_exp(grant(z, 2, 6'b001000, 2, 1, 5), 6'b001000, 6'b000100));
        for (int k = 0; k < 4; k++) tbl.push_back(with_exp(grant(z, 0, 1, 3, 0, k), 1, 1));
        tbl.push_back(with_exp(grant(z, 0, 1, 3, 0, 7), 0, 0));
        tbl.push_back(with_exp(ret(z, 0, 0), 0, 0));
        tbl.push_back(with_exp(grant(z, 0, 1, 1, 0, 6), 1, 1));
        for (int k = 0; k < 2; k++) tbl.push_back(with_exp(grant(z, 5, 6'b010000, 1, 3, 2), 6'b010000, 6'b100000));
        tbl.push_back(with_exp(ret(grant(z, 5, 6'b010000, 2, 3, 4), 5, 3), 6'b010000, 6'b100000));
        for (int k = 0; k < 2; k++) tbl.push_back(with_exp(grant(z, 5, 6'b010000, 0, 3, 1), 6'b010000, 6'b100000));
        tbl.push_back(with_exp(grant(z, 5, 6'b010000, 0, 3, 1), 0, 0));
        tbl.push_back(with_exp(ret(z, 3, 2), 0, 0));
        tbl.push_back(with_exp(grant(z, 3, 0, 1, 1, 3), 0, 0));
        tbl.push_back(with_exp(grant(z, 3, 6'b110100, 3, 0, 6), 6'b000100, 6'b001000));
        tbl.push_back(with_exp(grant(grant(z, 1, 1, 1, 0, 2), 4, 1, 3, 2, 6), 6'b000001, 6'b010010));

        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        step(z, 0);
        chk("rst_avail", 64'(vc_credit_avail_o), 64'(24'hFFFFFF));
        chk("rst_vld", 64'(outport_vld_o), 64'd0);
        chk("rst_ovf", 64'(credit_overflow_err_o), 64'd0);
        chk("rst_conf", 64'(inport_conflict_err_o), 64'd0);

        foreach (tbl[k]) step(tbl[k], 1);
        step(z, 0);
        chk("ovf_sticky", 64'(credit_overflow_err_o), 64'd1);
        chk("conf_sticky", 64'(inport_conflict_err_o), 64'd1);

        // Reset asserted while a launch is in flight.
        t = grant(z, 2, 6'b001000, 1, 1, 5);
        step(t, 0);
        chk("pre_rst_vld", 64'(outport_vld_o[2]), 64'd1);
        cur = t;
        #4;
        rstn = 1'b0;
        #1;
        chk("midrst_vld", 64'(outport_vld_o), 64'd0);
        chk("midrst_avail", 64'(vc_credit_avail_o), 64'(24'hFFFFFF));
        chk("midrst_sel", 64'(outport_select_inport_id_o), 64'd0);
        chk("midrst_ovf", 64'(credit_overflow_err_o), 64'd0);
        cur = z;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        chk("post_rst_vld", 64'(outport_vld_o), 64'd0);
        step(z, 0);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) step(rand_vec(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/input_to_output_credit_pipe.md
Name: input_to_output_credit_pipe

Overview:
- Parametrised next-generation switch-traversal stage of the router.
- Takes per-outport switch-allocator (SA) global grants and VC assignments, then qualifies each grant against a per-outport, per-VC downstream credit counter.
- For each qualified grant it drives the input-buffer read (enable and VC id) combinationally, and launches a registered outport crossbar select, VC id and look-ahead route one cycle later.
- Replaces fixed-turn decoding with a full INPUT_PORT_NUM x OUTPUT_PORT_NUM one-hot, and adds credit bookkeeping and error flags.

Parameters:
- INPUT_PORT_NUM, 6, number of input ports.
- OUTPUT_PORT_NUM, 6, number of output ports.
- VC_NUM, 4, VCs per outport.
- VC_ID_W, clog2(VC_NUM) (min 1), VC id width.
- INPORT_ID_W, clog2(INPUT_PORT_NUM) (min 1), encoded inport id width.
- VC_DEPTH, 4, downstream buffer depth per VC; this is the credit counter reset/maximum value.
- CRD_W, clog2(VC_DEPTH+1), credit counter width.
- LA_ROUTE_W, 3, look-ahead routing field width.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- sa_global_vld_i  in  OUTPUT_PORT_NUM  SA grant valid, per outport.
- sa_global_inport_id_oh_i  in  OUTPUT_PORT_NUM*INPUT_PORT_NUM  granted inport, one-hot, per outport.
- sa_global_inport_vc_id_i  in  OUTPUT_PORT_NUM*VC_ID_W  input VC of the granted flit.
- vc_assignment_vld_i  in  OUTPUT_PORT_NUM  downstream VC assigned.
- vc_assignment_vc_id_i  in  OUTPUT_PORT_NUM*VC_ID_W  downstream VC id.
- look_ahead_routing_sel_i  in  OUTPUT_PORT_NUM*LA_ROUTE_W  next-hop route.
- credit_return_vld_i  in  OUTPUT_PORT_NUM  downstream credit return.
- credit_return_vc_id_i  in  OUTPUT_PORT_NUM*VC_ID_W  VC of the returned credit.
- inport_read_enable_o  out  INPUT_PORT_NUM  input buffer pop.
- inport_read_vc_id_o  out  INPUT_PORT_NUM*VC_ID_W  VC to pop.
- outport_vld_o  out  OUTPUT_PORT_NUM  registered crossbar valid.
- outport_select_inport_id_o  out  OUTPUT_PORT_NUM*INPORT_ID_W  registered crossbar select.
- outport_vc_id_o  out  OUTPUT_PORT_NUM*VC_ID_W  registered downstream VC.
- outport_look_ahead_routing_o  out  OUTPUT_PORT_NUM*LA_ROUTE_W  registered route.
- vc_credit_avail_o  out  OUTPUT_PORT_NUM*VC_NUM  credit counter non-zero.
- credit_overflow_err_o  out  1  sticky: a credit was returned while its counter was already full.
- inport_conflict_err_o  out  1  sticky: two fires targeted one inport in the same cycle.

Behaviour:
- Decode per outport o:
  - sel = lowest set bit of the inport one-hot.
  - fire[o] = sa_global_vld_i[o] & vc_assignment_vld_i[o] & (one-hot != 0) & (crd[o][vc_assignment_vc_id_i[o]] != 0).
- Read path, combinational, same cycle as the grant:
  - inport_read_enable_o[i] = OR over o of (fire[o] & sel[o]==i).
  - inport_read_vc_id_o[i] = sa_global_inport_vc_id_i of the lowest-index outport firing on i; 0 when not enabled.
- Launch path, one cycle latency: on each clk edge,
  - outport_vld_o[o] <= fire[o].
  - When fire[o], capture the encoded sel, vc_assignment_vc_id_i[o] and look_ahead_routing_sel_i[o].
  - When fire[o] is low, the data registers hold their previous values; consumers must qualify them with outport_vld_o.
- Credit counters crd[o][v], each CRD_W bits wide:
  - dec = fire[o] & assigned VC == v.
  - inc = credit_return_vld_i[o] & return VC == v.
  - dec & inc: counter unchanged.
  - inc only with crd == VC_DEPTH: counter saturates at VC_DEPTH and credit_overflow_err_o is set.
  - dec can never underflow, because fire is gated by a non-zero count.
- vc_credit_avail_o[o*VC_NUM+v] = (crd[o][v] != 0), combinational from the registers.
- inport_conflict_err_o is set when more than one outport fires on the same inport in a cycle. All of those fires still proceed and consume credit; the flag is for verification only.
- Error flags clear only on reset.
- Reset (asynchronous assert, synchronous release):
  - every crd = VC_DEPTH;
  - outport_vld_o = 0, all outport data registers = 0;
  - both error flags = 0.
  - Combinational outputs follow the inputs during reset but do not fire when any counter is unavailable.
  - Reset mid-traffic drops any in-flight launch: outport_vld_o is 0 on the first cycle after rstn deasserts.

Test Plan:
- Reset then idle → vc_credit_avail_o all 1, outport_vld_o=0, error flags 0.
- Outport 2, inport one-hot 6'b001000, vc_assign vld, VC 1, LA route 3'd5 → same cycle inport_read_enable_o[3]=1 with the input VC id driven; next cycle outport_vld_o[2]=1, select=3, vc=1, route=5; crd[2][1] goes 4→3.
- Four back-to-back grants to outport 0 VC 0, then a fifth → fifth has no fire, no read enable; vc_credit_avail_o[0]=0; one credit return → avail=1 next cycle, sixth grant fires.
- Grant and credit return on the same outport/VC in one cycle at count 2 → count stays 2.
- Credit return at count 4 → count stays 4, credit_overflow_err_o=1 and stays 1 until reset.
- Outports 1 and 4 both select inport 0 in one cycle → both fire, read_vc_id taken from outport 1, inport_conflict_err_o=1; assert rstn low mid-stream → outport_vld_o=0 and counters=4 immediately.
